// File: rtl/rv_opnd_stage.sv
// ============================================================================
// rv_opnd_stage : RV64 operand-fetch stage (RF read, EX/MEM/WB bypass, load-use bubble)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module rv_opnd_stage #(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush_i,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [REGW-1:0] id_rs1_i,
    input  logic [REGW-1:0] id_rs2_i,
    input  logic [REGW-1:0] id_rd_i,
    input  logic            id_rd_wen_i,
    input  logic            id_is_load_i,
    input  logic [XLEN-1:0] id_pc_i,
    output logic            rf_rd_en_o,
    output logic [REGW-1:0] rf_rd_reg1_o,
    output logic [REGW-1:0] rf_rd_reg2_o,
    input  logic [XLEN-1:0] rf_rd_data1_i,
    input  logic [XLEN-1:0] rf_rd_data2_i,
    input  logic            ex_fwd_en_i,
    input  logic [REGW-1:0] ex_fwd_rd_i,
    input  logic [XLEN-1:0] ex_fwd_data_i,
    input  logic            ex_is_load_i,
    input  logic            mem_fwd_en_i,
    input  logic [REGW-1:0] mem_fwd_rd_i,
    input  logic [XLEN-1:0] mem_fwd_data_i,
    input  logic            wb_en_i,
    input  logic [REGW-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_op1_o,
    output logic [XLEN-1:0] ex_op2_o,
    output logic [REGW-1:0] ex_rd_o,
    output logic            ex_rd_wen_o,
    output logic            ex_is_load_o,
    output logic [XLEN-1:0] ex_pc_o
);

    logic            valid_a_q;
    logic [REGW-1:0] a_rs1_q, a_rs2_q, a_rd_q;
    logic            a_rd_wen_q, a_is_load_q;
    logic [XLEN-1:0] a_pc_q;

    logic            snap_en_q;
    logic [REGW-1:0] snap_rd_q;
    logic [XLEN-1:0] snap_data_q;

    logic            ex_valid_q;
    logic [XLEN-1:0] ex_op1_q, ex_op2_q, ex_pc_q;
    logic [REGW-1:0] ex_rd_q;
    logic            ex_rd_wen_q, ex_is_load_q;

    logic            w_out_adv, w_luse, w_a_adv, w_accept;
    logic [XLEN-1:0] op1_d, op2_d;

    // Youngest producer wins; the snapshot stands in for a WB write that landed
    // on the same edge as the RF read and is therefore missing from rf_data.
    function automatic logic [XLEN-1:0] resolve(
        input logic [REGW-1:0] rs,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_en,
        input logic [REGW-1:0] ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            ex_ld,
        input logic            mem_en,
        input logic [REGW-1:0] mem_rd,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_en,
        input logic [REGW-1:0] wb_rd,
        input logic [XLEN-1:0] wb_data,
        input logic            sn_en,
        input logic [REGW-1:0] sn_rd,
        input logic [XLEN-1:0] sn_data
    );
        if (rs == '0)                               return '0;
        else if (ex_en && ex_rd == rs && !ex_ld)    return ex_data;
        else if (mem_en && mem_rd == rs)            return mem_data;
        else if (wb_en && wb_rd == rs)              return wb_data;
        else if (sn_en && sn_rd == rs)              return sn_data;
        else                                        return rf_data;
    endfunction

    always_comb begin
        w_out_adv  = !ex_valid_q || ex_ready_i;
        w_luse     = valid_a_q && ex_is_load_i && ex_fwd_en_i && (ex_fwd_rd_i != '0) &&
                     (ex_fwd_rd_i == a_rs1_q || ex_fwd_rd_i == a_rs2_q);
        w_a_adv    = valid_a_q && !w_luse && w_out_adv;
        id_ready_o = !flush_i && (!valid_a_q || w_a_adv);
        w_accept   = id_valid_i && id_ready_o;
        op1_d = resolve(a_rs1_q, rf_rd_data1_i, ex_fwd_en_i, ex_fwd_rd_i, ex_fwd_data_i,
                        ex_is_load_i, mem_fwd_en_i, mem_fwd_rd_i, mem_fwd_data_i,
                        wb_en_i, wb_rd_i, wb_data_i, snap_en_q, snap_rd_q, snap_data_q);
        op2_d = resolve(a_rs2_q, rf_rd_data2_i, ex_fwd_en_i, ex_fwd_rd_i, ex_fwd_data_i,
                        ex_is_load_i, mem_fwd_en_i, mem_fwd_rd_i, mem_fwd_data_i,
                        wb_en_i, wb_rd_i, wb_data_i, snap_en_q, snap_rd_q, snap_data_q);
    end

    // Read the indices slot A will hold after the edge so its data arrives in step.
    assign rf_rd_en_o   = rstn;
    assign rf_rd_reg1_o = !rstn ? '0 : (w_accept ? id_rs1_i : a_rs1_q);
    assign rf_rd_reg2_o = !rstn ? '0 : (w_accept ? id_rs2_i : a_rs2_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_a_q   <= 1'b0;
            a_rs1_q     <= '0;
            a_rs2_q     <= '0;
            a_rd_q      <= '0;
            a_rd_wen_q  <= 1'b0;
            a_is_load_q <= 1'b0;
            a_pc_q      <= '0;
            snap_en_q   <= 1'b0;
            snap_rd_q   <= '0;
            snap_data_q <= '0;
        end else begin
            snap_en_q   <= wb_en_i;
            snap_rd_q   <= wb_rd_i;
            snap_data_q <= wb_data_i;
            if (flush_i) begin
                valid_a_q <= 1'b0;
            end else if (w_accept) begin
                valid_a_q   <= 1'b1;
                a_rs1_q     <= id_rs1_i;
                a_rs2_q     <= id_rs2_i;
                a_rd_q      <= id_rd_i;
                a_rd_wen_q  <= id_rd_wen_i;
                a_is_load_q <= id_is_load_i;
                a_pc_q      <= id_pc_i;
            end else if (w_a_adv) begin
                valid_a_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid_q   <= 1'b0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            ex_rd_q      <= '0;
            ex_rd_wen_q  <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_pc_q      <= '0;
        end else if (flush_i) begin
            ex_valid_q <= 1'b0;
        end else if (w_a_adv) begin
            ex_valid_q   <= 1'b1;
            ex_op1_q     <= op1_d;
            ex_op2_q     <= op2_d;
            ex_rd_q      <= a_rd_q;
            ex_rd_wen_q  <= a_rd_wen_q;
            ex_is_load_q <= a_is_load_q;
            ex_pc_q      <= a_pc_q;
        end else if (w_out_adv) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_op1_o     = ex_op1_q;
    assign ex_op2_o     = ex_op2_q;
    assign ex_rd_o      = ex_rd_q;
    assign ex_rd_wen_o  = ex_rd_wen_q;
    assign ex_is_load_o = ex_is_load_q;
    assign ex_pc_o      = ex_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_opnd_stage.sv
// ============================================================================
// tb_rv_opnd_stage : randomized bench with architectural register-file model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_rv_opnd_stage;

    localparam int XLEN = 64;
    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            flush_i = 1'b0;
    logic            id_valid_i = 1'b0;
    logic            id_ready_o;
    logic [REGW-1:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
    logic            id_rd_wen_i = 1'b0, id_is_load_i = 1'b0;
    logic [XLEN-1:0] id_pc_i = '0;
    logic            rf_rd_en_o;
    logic [REGW-1:0] rf_rd_reg1_o, rf_rd_reg2_o;
    logic [XLEN-1:0] rf_rd_data1_i = '0, rf_rd_data2_i = '0;
    logic            ex_fwd_en_i = 1'b0, ex_is_load_i = 1'b0;
    logic [REGW-1:0] ex_fwd_rd_i = '0;
    logic [XLEN-1:0] ex_fwd_data_i = '0;
    logic            mem_fwd_en_i = 1'b0;
    logic [REGW-1:0] mem_fwd_rd_i = '0;
    logic [XLEN-1:0] mem_fwd_data_i = '0;
    logic            wb_en_i = 1'b0;
    logic [REGW-1:0] wb_rd_i = '0;
    logic [XLEN-1:0] wb_data_i = '0;
    logic            ex_valid_o;
    logic            ex_ready_i = 1'b0;
    logic [XLEN-1:0] ex_op1_o, ex_op2_o, ex_pc_o;
    logic [REGW-1:0] ex_rd_o;
    logic            ex_rd_wen_o, ex_is_load_o;

    always #5 clk = ~clk;

    rv_opnd_stage #(.XLEN(XLEN), .REGW(REGW)) u_dut (
        .clk(clk), .rstn(rstn), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rd_wen_i(id_rd_wen_i), .id_is_load_i(id_is_load_i), .id_pc_i(id_pc_i),
        .rf_rd_en_o(rf_rd_en_o), .rf_rd_reg1_o(rf_rd_reg1_o), .rf_rd_reg2_o(rf_rd_reg2_o),
        .rf_rd_data1_i(rf_rd_data1_i), .rf_rd_data2_i(rf_rd_data2_i),
        .ex_fwd_en_i(ex_fwd_en_i), .ex_fwd_rd_i(ex_fwd_rd_i),
        .ex_fwd_data_i(ex_fwd_data_i), .ex_is_load_i(ex_is_load_i),
        .mem_fwd_en_i(mem_fwd_en_i), .mem_fwd_rd_i(mem_fwd_rd_i), .mem_fwd_data_i(mem_fwd_data_i),
        .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .ex_rd_o(ex_rd_o),
        .ex_rd_wen_o(ex_rd_wen_o), .ex_is_load_o(ex_is_load_o), .ex_pc_o(ex_pc_o)
    );

    // Register file: registered read returning pre-edge contents; x0 is deliberately writable
    logic [XLEN-1:0] regs [32];
    always @(posedge clk) begin
        rf_rd_data1_i <= regs[rf_rd_reg1_o];
        rf_rd_data2_i <= regs[rf_rd_reg2_o];
        if (wb_en_i) regs[wb_rd_i] <= wb_data_i;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Transaction-level model: pending instruction and instruction presented to EX
    logic            m_av, m_ov;
    logic [REGW-1:0] a_rs1, a_rs2, a_rd;
    logic            a_wen, a_ld;
    logic [XLEN-1:0] a_pc;
    logic [XLEN-1:0] o_op1, o_op2, o_pc;
    logic [REGW-1:0] o_rd;
    logic            o_wen, o_ld;
    logic            p_ready, p_accept, p_aadv, p_outadv, p_flush;
    logic [XLEN-1:0] p_op1, p_op2;

    // Architectural value of r right now: newest in-flight result, else committed file
    function automatic logic [XLEN-1:0] arch_val(input logic [REGW-1:0] r);
        if (r == 0) return '0;
        if (ex_fwd_en_i && ex_fwd_rd_i == r && !ex_is_load_i) return ex_fwd_data_i;
        if (mem_fwd_en_i && mem_fwd_rd_i == r) return mem_fwd_data_i;
        if (wb_en_i && wb_rd_i == r) return wb_data_i;
        return regs[r];
    endfunction

    task automatic model_reset();
        m_av = 0; m_ov = 0;
        a_rs1 = 0; a_rs2 = 0; a_rd = 0; a_wen = 0; a_ld = 0; a_pc = 0;
        o_op1 = 0; o_op2 = 0; o_pc = 0; o_rd = 0; o_wen = 0; o_ld = 0;
    endtask

    task automatic check_outputs();
        check("ex_valid", 64'(ex_valid_o), 64'(m_ov));
        if (m_ov) begin
            check("ex_op1", ex_op1_o, o_op1);
            check("ex_op2", ex_op2_o, o_op2);
            check("ex_rd",  64'(ex_rd_o), 64'(o_rd));
            check("ex_ctl", 64'({ex_rd_wen_o, ex_is_load_o}), 64'({o_wen, o_ld}));
            check("ex_pc",  ex_pc_o, o_pc);
        end
    endtask

    task automatic step(input int ready_pct, input int flush_pct);
        logic load_hit;
        @(negedge clk);
        check_outputs();
        flush_i       = ($urandom_range(0, 99) < flush_pct);
        id_valid_i    = ($urandom_range(0, 99) < 75);
        id_rs1_i      = REGW'($urandom_range(0, 7));
        id_rs2_i      = REGW'($urandom_range(0, 7));
        id_rd_i       = REGW'($urandom_range(0, 7));
        id_rd_wen_i   = 1'($urandom);
        id_is_load_i  = 1'($urandom);
        id_pc_i       = {$urandom, $urandom};
        ex_fwd_en_i   = ($urandom_range(0, 99) < 50);
        ex_fwd_rd_i   = REGW'($urandom_range(0, 7));
        ex_fwd_data_i = {$urandom, $urandom};
        ex_is_load_i  = ($urandom_range(0, 99) < 30);
        mem_fwd_en_i  = ($urandom_range(0, 99) < 50);
        mem_fwd_rd_i  = REGW'($urandom_range(0, 7));
        mem_fwd_data_i = {$urandom, $urandom};
        wb_en_i       = ($urandom_range(0, 99) < 50);
        wb_rd_i       = REGW'($urandom_range(0, 7));
        wb_data_i     = {$urandom, $urandom};
        ex_ready_i    = ($urandom_range(0, 99) < ready_pct);
        #1;
        load_hit = m_av && ex_is_load_i && ex_fwd_en_i && ex_fwd_rd_i != 0 &&
                   (ex_fwd_rd_i == a_rs1 || ex_fwd_rd_i == a_rs2);
        p_flush  = flush_i;
        p_outadv = !m_ov || ex_ready_i;
        p_aadv   = m_av && !load_hit && p_outadv;
        p_ready  = !flush_i && (!m_av || p_aadv);
        p_accept = id_valid_i && p_ready;
        p_op1    = arch_val(a_rs1);
        p_op2    = arch_val(a_rs2);
        check("id_ready", 64'(id_ready_o), 64'(p_ready));
        check("rf_reg1", 64'(rf_rd_reg1_o), 64'(p_accept ? id_rs1_i : a_rs1));
        check("rf_reg2", 64'(rf_rd_reg2_o), 64'(p_accept ? id_rs2_i : a_rs2));
        @(posedge clk);
        if (p_flush) begin
            m_av = 0; m_ov = 0;
        end else begin
            if (p_aadv) begin
                o_op1 = p_op1; o_op2 = p_op2; o_rd = a_rd;
                o_wen = a_wen; o_ld = a_ld; o_pc = a_pc; m_ov = 1;
            end else if (p_outadv) begin
                m_ov = 0;
            end
            if (p_accept) begin
                a_rs1 = id_rs1_i; a_rs2 = id_rs2_i; a_rd = id_rd_i;
                a_wen = id_rd_wen_i; a_ld = id_is_load_i; a_pc = id_pc_i; m_av = 1;
            end else if (p_aadv) begin
                m_av = 0;
            end
        end
    endtask

    task automatic reset_mid_stream();
        @(negedge clk);
        check_outputs();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 64'(ex_valid_o), 64'(0));
        check("rst_op1", ex_op1_o, '0);
        check("rst_op2", ex_op2_o, '0);
        check("rst_ctl", 64'({ex_rd_o, ex_rd_wen_o, ex_is_load_o}), 64'(0));
        check("rst_pc", ex_pc_o, '0);
        check("rst_rf", 64'({rf_rd_en_o, rf_rd_reg1_o, rf_rd_reg2_o}), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        flush_i = 1'b0;
        #1;
        check("rst_id_ready", 64'(id_ready_o), 64'(1));
        check("rf_en", 64'(rf_rd_en_o), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
        model_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs();
        check("reset_rf_en", 64'(rf_rd_en_o), 64'(0));
        rstn = 1'b1;
        for (int i = 0; i < 1500; i++) step(90, 2);
        for (int i = 0; i < 1500; i++) step(30, 2);
        for (int i = 0; i < 20; i++) step(10, 0);
        reset_mid_stream();
        for (int i = 0; i < 1000; i++) step(60, 5);
        @(negedge clk);
        check_outputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv_opnd_stage.md
Name: rv_opnd_stage

Overview:
- Operand-fetch stage between decode and execute in the RV64 pipeline.
- Accepts decoded instructions on a valid/ready handshake and drives the register-file read port. The register file returns data one cycle after the read is enabled.
- Resolves RAW hazards by bypassing from EX, MEM and WB, and inserts a one-cycle bubble on load-use hazards.
- Presents resolved 64-bit operands to EX through a registered valid/ready output.

Parameters:
XLEN, 64, operand/data width
REGW, 5, register index width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush_i  in  1  synchronous kill of all held instructions
id_valid_i  in  1  decode has an instruction
id_ready_o  out  1  stage accepts the instruction this cycle
id_rs1_i  in  REGW  source 1 index
id_rs2_i  in  REGW  source 2 index
id_rd_i  in  REGW  destination index
id_rd_wen_i  in  1  instruction writes rd
id_is_load_i  in  1  instruction is a load
id_pc_i  in  XLEN  instruction PC
rf_rd_en_o  out  1  register-file read enable
rf_rd_reg1_o  out  REGW  register-file read index 1
rf_rd_reg2_o  out  REGW  register-file read index 2
rf_rd_data1_i  in  XLEN  register-file data 1 (registered, 1-cycle latency)
rf_rd_data2_i  in  XLEN  register-file data 2
ex_fwd_en_i, ex_fwd_rd_i, ex_fwd_data_i, ex_is_load_i  in  1/REGW/XLEN/1  EX-stage result bypass
mem_fwd_en_i, mem_fwd_rd_i, mem_fwd_data_i  in  1/REGW/XLEN  MEM-stage bypass
wb_en_i, wb_rd_i, wb_data_i  in  1/REGW/XLEN  WB write; identical to the register-file write port
ex_valid_o  out  1  output holds an instruction
ex_ready_i  in  1  EX accepts
ex_op1_o, ex_op2_o  out  XLEN  resolved operands
ex_rd_o, ex_rd_wen_o, ex_is_load_o, ex_pc_o  out  REGW/1/1/XLEN  forwarded control fields

Behaviour:
- Storage: two slots.
  - Slot A (read in flight): valid_a, rs1, rs2, rd, rd_wen, is_load, pc, plus a WB snapshot (snap_en, snap_rd, snap_data).
  - Output register: drives all ex_* outputs.
- Reset:
  - valid_a = 0, ex_valid_o = 0.
  - All ex_* data/control outputs = 0, snapshot cleared.
  - rf_rd_en_o = 0, rf_rd_reg*_o = 0.
- out_adv = !ex_valid_o || ex_ready_i.
- Load-use stall (luse): valid_a && ex_is_load_i && ex_fwd_en_i && ex_fwd_rd_i != 0 && (ex_fwd_rd_i == A.rs1 || ex_fwd_rd_i == A.rs2).
- a_adv = valid_a && !luse && out_adv.
- id_ready_o = !flush_i && (!valid_a || a_adv); combinational.
- Register-file read:
  - rf_rd_en_o = 1 every cycle out of reset.
  - rf_rd_reg1_o/rf_rd_reg2_o = the rs indices slot A will hold after the edge: incoming id rs on accept, otherwise the current A.rs.
  - Data arriving for slot A therefore always reflects register-file state immediately before the latest edge.
- WB snapshot: on every edge, snap_{en,rd,data} <= wb_{en,rd,data}_i. This covers a write and a read hitting the register file on the same edge, where the register file returns the old value.
- Operand resolution for each source rs, evaluated combinationally while slot A is valid:
  - rs == 0 -> 0; x0 is forced to zero regardless of register-file contents.
  - else ex_fwd_en_i && ex_fwd_rd_i == rs && !ex_is_load_i -> ex_fwd_data_i.
  - else mem_fwd_en_i && mem_fwd_rd_i == rs -> mem_fwd_data_i.
  - else wb_en_i && wb_rd_i == rs -> wb_data_i.
  - else snap_en && snap_rd == rs -> snap_data.
  - else rf_rd_data_i.
- Output register update:
  - on a_adv: load resolved operands and A control; ex_valid_o <= 1.
  - else if out_adv: ex_valid_o <= 0 (bubble on luse or empty A); data outputs hold.
  - Output is held unchanged while ex_valid_o && !ex_ready_i.
- Slot A update: on id accept, load from id_*; else on a_adv, valid_a <= 0.
- Latency: accept at edge N -> ex_valid_o at edge N+1 with no hazard; N+2 with a load-use stall. Throughput is 1 instruction/cycle.
- flush_i has priority over all updates: at the edge, valid_a <= 0 and ex_valid_o <= 0; the id accept is suppressed.

Test Plan:
- Reset mid-stream: rstn low while both slots are valid -> ex_valid_o = 0 and all ex_* = 0 immediately (asynchronous); id_ready_o = 1 after release.
- Back-to-back RAW: ADDI x5 <- EX result 0x10, next instruction rs1 = x5 -> ex_op1_o = 0x10 via EX bypass with no bubble; x5 in MEM with value 0x20 -> 0x20.
- Load-use: load to x7 in EX, consumer rs2 = x7 -> exactly one bubble (ex_valid_o = 0 for one cycle); next cycle ex_op2_o = mem_fwd_data_i (0xDEAD).
- Same-edge WB: wb writes x3 = 0x55 on the read edge, register file returns old 0 -> ex_op1_o = 0x55 via the snapshot.
- x0 and backpressure: rs1 = 0 while ex_fwd_rd_i = 0 with data 0xFF -> op1 = 0; ex_ready_i low for 3 cycles -> outputs stable and id_ready_o = 0 with slot A full.
- Flush: flush_i with id_valid_i = 1 -> instruction dropped, ex_valid_o = 0 next cycle.
